// File: rtl/icache_req_dispatch.sv
// icache_req_dispatch: routes arbiter-granted I-cache requests into a
// two-entry in-order lookup FIFO, and walks every set for invalidate-all.
// Optional macro ICACHE_PF_FILTER_EN drops prefetches that hit the line of
// the last accepted cpu fetch.
module icache_req_dispatch #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SET_NUM    = 64,
  parameter int unsigned LINE_OFF_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arb_valid,
  input  logic [2:0]                   arb_grant,
  input  logic [ADDR_W-1:0]            arb_addr,
  output logic                         arb_ready,
  output logic                         lkp_valid,
  input  logic                         lkp_ready,
  output logic [ADDR_W-1:0]            lkp_addr,
  output logic                         lkp_is_pf,
  output logic                         inv_we,
  output logic [$clog2(SET_NUM)-1:0]   inv_idx,
  output logic                         inv_done,
  output logic                         err_onehot,
  output logic                         pf_drop
);

  localparam int unsigned IDX_W = $clog2(SET_NUM);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INV_WAIT = 2'd1,
    INV_WALK = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_pf;
  } entry_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             inv_we_nxt, inv_done_nxt, err_nxt, pf_drop_nxt;

  // Shift-style FIFO: entry 0 is always the head, so outputs come straight from flops
  entry_t           ent0, ent1, ent_new;
  logic             vld0, vld1;

  logic             pop, accept, grant_onehot, req_fetch, req_inv, push, filt_hit;

  // Handshake and request decode
  always_comb begin
    pop          = vld0 & lkp_ready;
    arb_ready    = rst_n & (state == IDLE) & (~vld1 | pop);
    accept       = arb_valid & arb_ready;
    grant_onehot = (arb_grant == 3'b001) | (arb_grant == 3'b010) | (arb_grant == 3'b100);
    req_fetch    = accept & grant_onehot & ~arb_grant[1];
    req_inv      = accept & grant_onehot &  arb_grant[1];
    push         = req_fetch & ~filt_hit;
    pf_drop_nxt  = req_fetch & filt_hit;
    ent_new      = '{addr: arb_addr, is_pf: arb_grant[2]};
  end

  assign lkp_valid = vld0;
  assign lkp_addr  = ent0.addr;
  assign lkp_is_pf = ent0.is_pf;

`ifdef ICACHE_PF_FILTER_EN
  localparam int unsigned LINE_W = ADDR_W - LINE_OFF_W;

  logic [LINE_W-1:0] last_line;
  logic              last_vld;

  // Prefetch hits the line most recently fetched by the cpu
  always_comb begin
    filt_hit = arb_grant[2] & last_vld & (last_line == arb_addr[ADDR_W-1:LINE_OFF_W]);
  end

  // Track last accepted cpu fetch line; invalidate-all forgets it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_line <= '0;
      last_vld  <= 1'b0;
    end else if (req_inv) begin
      last_vld  <= 1'b0;
    end else if (req_fetch && arb_grant[0]) begin
      last_line <= arb_addr[ADDR_W-1:LINE_OFF_W];
      last_vld  <= 1'b1;
    end
  end
`else
  // No filtering: every prefetch is pushed
  always_comb begin
    filt_hit = 1'b0;
  end
`endif

  // Lookup FIFO storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      vld0 <= 1'b0;
      vld1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!vld0) begin
            ent0 <= ent_new;
            vld0 <= 1'b1;
          end else begin
            ent1 <= ent_new;
            vld1 <= 1'b1;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          vld0 <= vld1;
          vld1 <= 1'b0;
        end
        2'b11: begin
          if (vld1) begin
            ent0 <= ent1;
            ent1 <= ent_new;
          end else begin
            ent0 <= ent_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and registered control outputs
  always_comb begin
    state_nxt    = state;
    idx_nxt      = inv_idx;
    inv_we_nxt   = 1'b0;
    inv_done_nxt = 1'b0;
    err_nxt      = accept & ~grant_onehot;
    case (state)
      IDLE: begin
        if (req_inv) state_nxt = INV_WAIT;
      end
      INV_WAIT: begin
        if (!vld0 || (pop && !vld1)) begin
          state_nxt  = INV_WALK;
          inv_we_nxt = 1'b1;
          idx_nxt    = '0;
        end
      end
      INV_WALK: begin
        if (inv_idx == IDX_W'(SET_NUM - 1)) begin
          state_nxt    = IDLE;
          inv_done_nxt = 1'b1;
          idx_nxt      = '0;
        end else begin
          inv_we_nxt = 1'b1;
          idx_nxt    = inv_idx + IDX_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      inv_idx    <= '0;
      inv_we     <= 1'b0;
      inv_done   <= 1'b0;
      err_onehot <= 1'b0;
      pf_drop    <= 1'b0;
    end else begin
      state      <= state_nxt;
      inv_idx    <= idx_nxt;
      inv_we     <= inv_we_nxt;
      inv_done   <= inv_done_nxt;
      err_onehot <= err_nxt;
      pf_drop    <= pf_drop_nxt;
    end
  end

endmodule

// File: tb/tb_icache_req_dispatch.sv
// Directed bench for icache_req_dispatch (default parameters).
module tb_icache_req_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_valid;
  logic [2:0]  arb_grant;
  logic [31:0] arb_addr;
  logic        arb_ready;
  logic        lkp_valid;
  logic        lkp_ready;
  logic [31:0] lkp_addr;
  logic        lkp_is_pf;
  logic        inv_we;
  logic [5:0]  inv_idx;
  logic        inv_done;
  logic        err_onehot;
  logic        pf_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icache_req_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .arb_valid(arb_valid), .arb_grant(arb_grant), .arb_addr(arb_addr), .arb_ready(arb_ready),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_addr(lkp_addr), .lkp_is_pf(lkp_is_pf),
    .inv_we(inv_we), .inv_idx(inv_idx), .inv_done(inv_done),
    .err_onehot(err_onehot), .pf_drop(pf_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable here
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] g, input logic [31:0] a);
    arb_valid = v;
    arb_grant = g;
    arb_addr  = a;
  endtask

  initial begin
    rst_n = 1'b0; lkp_ready = 1'b1;
    drive(1'b0, 3'b000, 32'h0);
    step(); step(); step();
    chk("rst_arb_ready", 32'(arb_ready), 32'd0);
    chk("rst_lkp_valid", 32'(lkp_valid), 32'd0);
    chk("rst_lkp_addr",  lkp_addr, 32'd0);
    chk("rst_lkp_is_pf", 32'(lkp_is_pf), 32'd0);
    chk("rst_inv_we",    32'(inv_we), 32'd0);
    chk("rst_inv_idx",   32'(inv_idx), 32'd0);
    chk("rst_inv_done",  32'(inv_done), 32'd0);
    chk("rst_err",       32'(err_onehot), 32'd0);
    chk("rst_pf_drop",   32'(pf_drop), 32'd0);

    // Single cpu fetch, one-cycle latency
    rst_n = 1'b1; #1;
    chk("rel_arb_ready", 32'(arb_ready), 32'd1);
    drive(1'b1, 3'b001, 32'h1000);
    step(); drive(1'b0, 3'b000, 32'h0);
    chk("cpu_lkp_valid", 32'(lkp_valid), 32'd1);
    chk("cpu_lkp_addr",  lkp_addr, 32'h1000);
    chk("cpu_lkp_is_pf", 32'(lkp_is_pf), 32'd0);
    step();
    chk("cpu_drained", 32'(lkp_valid), 32'd0);

    // Fill FIFO with lookup stalled, then drain in order
    lkp_ready = 1'b0;
    drive(1'b1, 3'b001, 32'h40);
    step(); drive(1'b1, 3'b100, 32'h80); #1;
    chk("fill1_lkp_addr",  lkp_addr, 32'h40);
    chk("fill1_arb_ready", 32'(arb_ready), 32'd1);
    step(); drive(1'b0, 3'b000, 32'h0); #1;
    chk("full_arb_ready", 32'(arb_ready), 32'd0);
    chk("full_head", lkp_addr, 32'h40);
    lkp_ready = 1'b1; #1;
    chk("full_pop_arb_ready", 32'(arb_ready), 32'd1);
    step();
    chk("pop2_valid", 32'(lkp_valid), 32'd1);
    chk("pop2_addr",  lkp_addr, 32'h80);
    chk("pop2_is_pf", 32'(lkp_is_pf), 32'd1);
    step();
    chk("pop_empty", 32'(lkp_valid), 32'd0);

    // Back-to-back throughput with lkp_ready held high
    drive(1'b1, 3'b001, 32'h100);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("tput_addr", lkp_addr, 32'(i - 1) * 32'h100);
      chk("tput_ready", 32'(arb_ready), 32'd1);
      if (i < 4) arb_addr = 32'(i) * 32'h100;
      else       drive(1'b0, 3'b000, 32'h0);
    end
    step();
    chk("tput_empty", 32'(lkp_valid), 32'd0);

    // Invalidate with one entry pending: wait, then full walk
    lkp_ready = 1'b0;
    drive(1'b1, 3'b001, 32'h500);
    step(); drive(1'b1, 3'b010, 32'h0); #1;
    chk("inv_acc_ready", 32'(arb_ready), 32'd1);
    step(); drive(1'b0, 3'b000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("wait_inv_we",  32'(inv_we), 32'd0);
      chk("wait_ready",   32'(arb_ready), 32'd0);
      chk("wait_lkp_vld", 32'(lkp_valid), 32'd1);
      step();
    end
    lkp_ready = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      chk("walk_we",    32'(inv_we), 32'd1);
      chk("walk_idx",   32'(inv_idx), 32'(i));
      chk("walk_ready", 32'(arb_ready), 32'd0);
      chk("walk_lkp",   32'(lkp_valid), 32'd0);
      chk("walk_done",  32'(inv_done), 32'd0);
      step();
    end
    chk("done_pulse", 32'(inv_done), 32'd1);
    chk("done_we",    32'(inv_we), 32'd0);
    chk("done_idx",   32'(inv_idx), 32'd0);
    chk("done_ready", 32'(arb_ready), 32'd1);
    step();
    chk("done_once", 32'(inv_done), 32'd0);

    // Non-one-hot grants are dropped with an error pulse
    drive(1'b1, 3'b011, 32'h700);
    step(); drive(1'b1, 3'b000, 32'h740);
    chk("err011_pulse", 32'(err_onehot), 32'd1);
    chk("err011_nopush", 32'(lkp_valid), 32'd0);
    step(); drive(1'b0, 3'b000, 32'h0);
    chk("err000_pulse", 32'(err_onehot), 32'd1);
    chk("err000_nopush", 32'(lkp_valid), 32'd0);
    chk("err_idle_ready", 32'(arb_ready), 32'd1);
    step();
    chk("err_clear", 32'(err_onehot), 32'd0);
    chk("err_no_inv", 32'(inv_we), 32'd0);

    // Prefetch filter: same line dropped only when the filter is built in
    drive(1'b1, 3'b001, 32'h1000);
    step(); drive(1'b1, 3'b100, 32'h1020);
    chk("pf_cpu_addr", lkp_addr, 32'h1000);
    step(); drive(1'b1, 3'b100, 32'h1040);
`ifdef ICACHE_PF_FILTER_EN
    chk("pf_same_drop",  32'(pf_drop), 32'd1);
    chk("pf_same_valid", 32'(lkp_valid), 32'd0);
`else
    chk("pf_same_drop",  32'(pf_drop), 32'd0);
    chk("pf_same_valid", 32'(lkp_valid), 32'd1);
    chk("pf_same_addr",  lkp_addr, 32'h1020);
`endif
    step(); drive(1'b0, 3'b000, 32'h0);
    chk("pf_next_drop",  32'(pf_drop), 32'd0);
    chk("pf_next_addr",  lkp_addr, 32'h1040);
    chk("pf_next_is_pf", 32'(lkp_is_pf), 32'd1);
    step();
    chk("pf_empty", 32'(lkp_valid), 32'd0);

    // Reset in the middle of a walk aborts it
    drive(1'b1, 3'b010, 32'h0);
    step(); drive(1'b0, 3'b000, 32'h0);
    chk("abort_wait_ready", 32'(arb_ready), 32'd0);
    step();
    for (int i = 0; i < 11; i++) begin
      chk("abort_walk_idx", 32'(inv_idx), 32'(i));
      if (i < 10) step();
    end
    rst_n = 1'b0;
    step();
    chk("abort_we",    32'(inv_we), 32'd0);
    chk("abort_done",  32'(inv_done), 32'd0);
    chk("abort_idx",   32'(inv_idx), 32'd0);
    chk("abort_ready_in_rst", 32'(arb_ready), 32'd0);
    rst_n = 1'b1; #1;
    chk("abort_ready_rel", 32'(arb_ready), 32'd1);
    step();
    chk("abort_no_done", 32'(inv_done), 32'd0);
    chk("abort_no_we",   32'(inv_we), 32'd0);
    chk("abort_idle",    32'(arb_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
